// File: rtl/dla_debug_network_head_if.sv
// dla_debug_network_head_if: CSR request, ring in/out and status signals of the debug network head
interface dla_debug_network_head_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STRAY_WIDTH = 8
);
  localparam int BUS_WIDTH = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
  logic                   i_req_valid;
  logic [ADDR_WIDTH-1:0]  i_req_addr;
  logic                   o_req_ready;
  logic                   o_down_forced_valid;
  logic [BUS_WIDTH-1:0]   o_down_shared_bus;
  logic                   o_down_is_addr;
  logic                   i_up_forced_valid;
  logic [BUS_WIDTH-1:0]   i_up_shared_bus;
  logic                   i_up_is_addr;
  logic                   o_status_busy;
  logic                   o_status_valid;
  logic                   o_status_timeout;
  logic [DATA_WIDTH-1:0]  o_resp_data;
  logic [STRAY_WIDTH-1:0] o_stray_count;
  modport slave (
    input  i_req_valid, i_req_addr, i_up_forced_valid, i_up_shared_bus, i_up_is_addr,
    output o_req_ready, o_down_forced_valid, o_down_shared_bus, o_down_is_addr,
           o_status_busy, o_status_valid, o_status_timeout, o_resp_data, o_stray_count
  );
  modport master (
    output i_req_valid, i_req_addr, i_up_forced_valid, i_up_shared_bus, i_up_is_addr,
    input  o_req_ready, o_down_forced_valid, o_down_shared_bus, o_down_is_addr,
           o_status_busy, o_status_valid, o_status_timeout, o_resp_data, o_stray_count
  );
endinterface

// File: rtl/dla_debug_network_head.sv
// dla_debug_network_head: injects one read address onto the debug ring and caches the returning data word
module dla_debug_network_head #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int STRAY_WIDTH    = 8
) (
  input logic clk,
  input logic i_aresetn,
  dla_debug_network_head_if.slave bus
);
  localparam int BUS_WIDTH = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                 state_q;
  logic [TW-1:0]          timer_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   ready_q;
  logic                   down_valid_q;
  logic                   valid_q;
  logic                   timeout_q;
  logic [DATA_WIDTH-1:0]  resp_q;
  logic [STRAY_WIDTH-1:0] stray_q;
  logic                   hs;
  logic                   up_data;
  logic                   stray_inc;
  assign hs        = bus.i_req_valid & ready_q;
  assign up_data   = bus.i_up_forced_valid & ~bus.i_up_is_addr;
  // In WAIT only a non-matching address is unexpected; in IDLE every returning word is
  assign stray_inc = bus.i_up_forced_valid &
                     ((state_q == IDLE) | (bus.i_up_is_addr & (bus.i_up_shared_bus != BUS_WIDTH'(addr_q))));
  always_ff @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      addr_q       <= '0;
      ready_q      <= 1'b0;
      down_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      resp_q       <= '0;
      stray_q      <= '0;
    end else begin
      down_valid_q <= hs;
      if (stray_inc && stray_q != '1) stray_q <= stray_q + 1'b1;
      if (hs) begin
        addr_q    <= bus.i_req_addr;
        state_q   <= WAIT;
        timer_q   <= '0;
        valid_q   <= 1'b0;
        timeout_q <= 1'b0;
        ready_q   <= 1'b0;
      end else if (state_q == WAIT) begin
        if (up_data) begin
          resp_q  <= bus.i_up_shared_bus[DATA_WIDTH-1:0];
          valid_q <= 1'b1;
          state_q <= IDLE;
          ready_q <= 1'b1;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_q <= 1'b1;
          state_q   <= IDLE;
          ready_q   <= 1'b1;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end else begin
        ready_q <= 1'b1;
      end
    end
  end
  assign bus.o_req_ready         = ready_q;
  assign bus.o_down_forced_valid = down_valid_q;
  assign bus.o_down_shared_bus   = down_valid_q ? BUS_WIDTH'(addr_q) : '0;
  assign bus.o_down_is_addr      = down_valid_q;
  assign bus.o_status_busy       = state_q == WAIT;
  assign bus.o_status_valid      = valid_q;
  assign bus.o_status_timeout    = timeout_q;
  assign bus.o_resp_data         = resp_q;
  assign bus.o_stray_count       = stray_q;
endmodule

// File: tb/tb_dla_debug_network_head.sv
// tb_dla_debug_network_head: directed read/timeout/stray scenarios checked against a cycle-stamp model
module tb_dla_debug_network_head;
  localparam int T  = 16;
  localparam int SW = 2;
  localparam int SMAX = (1 << SW) - 1;
  logic clk = 1'b0;
  logic i_aresetn = 1'b0;
  int checks = 0;
  int failures = 0;
  dla_debug_network_head_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRAY_WIDTH(SW)) bus_if ();
  dla_debug_network_head #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T), .STRAY_WIDTH(SW))
    dut (.clk(clk), .i_aresetn(i_aresetn), .bus(bus_if));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a request is outstanding from its handshake stamp until data returns or T cycles elapse
  int cyc, m_hs, m_stray;
  logic m_busy, m_ready, m_inj, m_valid, m_timeout;
  logic [31:0] m_addr, m_resp;
  always @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      cyc = 0; m_hs = 0; m_stray = 0; m_busy = 0; m_ready = 0; m_inj = 0;
      m_valid = 0; m_timeout = 0; m_addr = 0; m_resp = 0;
    end else begin
      automatic logic hs = bus_if.i_req_valid && m_ready;
      automatic logic fv = bus_if.i_up_forced_valid;
      automatic logic isa = bus_if.i_up_is_addr;
      if (!m_busy && fv && m_stray < SMAX) m_stray++;
      m_inj = hs;
      if (hs) begin
        m_busy = 1; m_hs = cyc; m_addr = bus_if.i_req_addr; m_valid = 0; m_timeout = 0;
      end else if (m_busy) begin
        if (fv && isa && bus_if.i_up_shared_bus != m_addr && m_stray < SMAX) m_stray++;
        if (fv && !isa) begin
          m_resp = bus_if.i_up_shared_bus; m_valid = 1; m_busy = 0;
        end else if (cyc - m_hs == T) begin
          m_timeout = 1; m_busy = 0;
        end
      end
      m_ready = !m_busy;
      cyc++;
    end
  end
  always @(negedge clk) begin
    if (i_aresetn) begin
      chk("ready", bus_if.o_req_ready, m_ready);
      chk("down_valid", bus_if.o_down_forced_valid, m_inj);
      if (m_inj) begin
        chk("down_bus", bus_if.o_down_shared_bus, m_addr);
        chk("down_is_addr", bus_if.o_down_is_addr, 1);
      end
      chk("busy", bus_if.o_status_busy, m_busy);
      chk("status_valid", bus_if.o_status_valid, m_valid);
      chk("status_timeout", bus_if.o_status_timeout, m_timeout);
      chk("resp_data", bus_if.o_resp_data, m_resp);
      chk("stray", bus_if.o_stray_count, m_stray);
    end
  end
  task automatic req(input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    bus_if.i_req_valid = 1; bus_if.i_req_addr = a;
    while (!bus_if.o_req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("req_ready_wait", 0, 1);
    @(negedge clk);
    bus_if.i_req_valid = 0;
  endtask
  task automatic ret(input logic [31:0] w, input logic isa);
    @(negedge clk);
    bus_if.i_up_forced_valid = 1; bus_if.i_up_shared_bus = w; bus_if.i_up_is_addr = isa;
    @(negedge clk);
    bus_if.i_up_forced_valid = 0; bus_if.i_up_is_addr = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, inj;
    bus_if.i_req_valid = 0; bus_if.i_req_addr = 0;
    bus_if.i_up_forced_valid = 0; bus_if.i_up_shared_bus = 0; bus_if.i_up_is_addr = 0;
    #12;
    chk("rst_ready", bus_if.o_req_ready, 0);
    chk("rst_stray", bus_if.o_stray_count, 0);
    @(negedge clk); i_aresetn = 1;
    @(negedge clk);
    chk("post_rst_ready", bus_if.o_req_ready, 1);
    // basic read
    req(32'h0200_0010);
    chk("inj_valid", bus_if.o_down_forced_valid, 1);
    chk("inj_bus", bus_if.o_down_shared_bus, 32'h0200_0010);
    chk("inj_busy", bus_if.o_status_busy, 1);
    repeat (4) @(negedge clk);
    ret(32'hDEAD_BEEF, 0);
    chk("basic_resp", bus_if.o_resp_data, 32'hDEAD_BEEF);
    chk("basic_valid", bus_if.o_status_valid, 1);
    chk("basic_busy", bus_if.o_status_busy, 0);
    chk("basic_stray", bus_if.o_stray_count, 0);
    // timeout, then a late data word
    req(32'h0200_0020);
    n = 1;
    while (!bus_if.o_status_timeout && n < 40) begin @(negedge clk); n++; end
    chk("timeout_latency", n, 17);
    chk("timeout_valid", bus_if.o_status_valid, 0);
    chk("timeout_ready", bus_if.o_req_ready, 1);
    repeat (2) @(negedge clk);
    ret(32'h1111_1111, 0);
    chk("late_resp", bus_if.o_resp_data, 32'hDEAD_BEEF);
    chk("late_stray", bus_if.o_stray_count, 1);
    // data in the final timeout cycle
    req(32'h0200_0030);
    repeat (14) @(negedge clk);
    ret(32'hCAFE_F00D, 0);
    chk("race_valid", bus_if.o_status_valid, 1);
    chk("race_timeout", bus_if.o_status_timeout, 0);
    chk("race_resp", bus_if.o_resp_data, 32'hCAFE_F00D);
    // address round trip: matching then non-matching
    req(32'h0200_0040);
    ret(32'h0200_0040, 1);
    chk("rt_match_stray", bus_if.o_stray_count, 1);
    ret(32'h0BAD_F00D, 0);
    chk("rt_resp", bus_if.o_resp_data, 32'h0BAD_F00D);
    req(32'h0200_0050);
    ret(32'h0300_0000, 1);
    chk("rt_mismatch_stray", bus_if.o_stray_count, 2);
    ret(32'h1234_5678, 0);
    // asynchronous reset mid-WAIT
    req(32'h0200_0060);
    repeat (2) @(negedge clk);
    #2 i_aresetn = 0;
    #1;
    chk("arst_busy", bus_if.o_status_busy, 0);
    chk("arst_ready", bus_if.o_req_ready, 0);
    chk("arst_valid", bus_if.o_status_valid, 0);
    chk("arst_resp", bus_if.o_resp_data, 0);
    chk("arst_stray", bus_if.o_stray_count, 0);
    chk("arst_down", {bus_if.o_down_forced_valid, bus_if.o_down_is_addr, bus_if.o_down_shared_bus}, 0);
    repeat (2) @(negedge clk);
    i_aresetn = 1;
    @(negedge clk);
    ret(32'h5555_5555, 0);
    chk("post_arst_stray", bus_if.o_stray_count, 1);
    chk("post_arst_valid", bus_if.o_status_valid, 0);
    // saturation
    for (int i = 0; i < 6; i++) ret(32'(i), i[0]);
    chk("sat_stray", bus_if.o_stray_count, 3);
    // backpressure: valid held through WAIT
    @(negedge clk);
    bus_if.i_req_valid = 1; bus_if.i_req_addr = 32'h0200_0070;
    inj = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus_if.o_down_forced_valid) inj++;
      if (i > 0) chk("bp_ready", bus_if.o_req_ready, 0);
    end
    chk("bp_injections", inj, 1);
    bus_if.i_req_valid = 0;
    ret(32'h7777_7777, 0);
    chk("bp_resp", bus_if.o_resp_data, 32'h7777_7777);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
